// File: rtl/ldm_stm_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_XFER,
        ST_WB,
        ST_DONE
    } state_e;

    localparam int WORD_BYTES = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ldm_stm_lsb_picker.sv
// Finds the lowest set bit of the remaining register list and clears it.
module ldm_stm_lsb_picker
    import ldm_stm_pkg::*;
(
    input  logic [15:0] list_i,
    output logic [3:0]  idx_o,
    output logic        valid_o,
    output logic [15:0] list_clr_o
);

    // Descending scan so the last (lowest) hit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (list_i[i]) begin
                idx_o   = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

    assign list_clr_o = list_i & (list_i - 16'd1);

endmodule

// File: rtl/ldm_stm_seq_ctrl.sv
// LDM/STM sequencer: one beat per listed register, ascending, plus base writeback.
// Optional PC-load fetch flush is built only when LDM_STM_PC_FLUSH_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_in, fields latched on start
// CALC  | popcount, start address and writeback value
// XFER  | one beat per set bit, advances on mem_ready_in
// WB    | base writeback strobe (suppressed when Rn is loaded)
// DONE  | one-cycle completion pulse
module ldm_stm_seq_ctrl
    import ldm_stm_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LIST_W = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic              p_in,
    input  logic              u_in,
    input  logic              w_in,
    input  logic              l_in,
    input  logic [3:0]        base_reg_in,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [LIST_W-1:0] reg_list_in,
    input  logic              mem_ready_in,
    output logic [3:0]        reg_addr_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic              mem_rd_en_out,
    output logic              mem_wr_en_out,
    output logic              rf_wr_en_out,
    output logic              wb_en_out,
    output logic [ADDR_W-1:0] wb_data_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              pc_flush_out
);

    localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(WORD_BYTES);

    state_e            state_q, state_d;
    logic              p_q, p_d;
    logic              u_q, u_d;
    logic              w_q, w_d;
    logic              l_q, l_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wb_val_q, wb_val_d;
    logic [LIST_W-1:0] list_q, list_d;
    logic [LIST_W-1:0] rem_q, rem_d;

    logic [3:0]        pick_idx;
    logic              pick_valid;
    logic [LIST_W-1:0] rem_next;
    logic [4:0]        n_c;
    logic [ADDR_W-1:0] span_c;
    logic [ADDR_W-1:0] start_addr_c;
    logic              wb_suppress_c;

    ldm_stm_lsb_picker u_picker (
        .list_i     (rem_q),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid),
        .list_clr_o (rem_next)
    );

    assign n_c    = popcount16(list_q);
    assign span_c = ADDR_W'(n_c) * WORD_INC;

    // Every mode walks upward from the lowest address of the block.
    always_comb begin
        case ({p_q, u_q})
            2'b01:   start_addr_c = base_q;
            2'b11:   start_addr_c = base_q + WORD_INC;
            2'b00:   start_addr_c = base_q - span_c + WORD_INC;
            default: start_addr_c = base_q - span_c;
        endcase
    end

    // A load that includes Rn already delivers its final value.
    assign wb_suppress_c = l_q & list_q[base_reg_q];

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            p_q        <= 1'b0;
            u_q        <= 1'b0;
            w_q        <= 1'b0;
            l_q        <= 1'b0;
            base_reg_q <= '0;
            base_q     <= '0;
            addr_q     <= '0;
            wb_val_q   <= '0;
            list_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            u_q        <= u_d;
            w_q        <= w_d;
            l_q        <= l_d;
            base_reg_q <= base_reg_d;
            base_q     <= base_d;
            addr_q     <= addr_d;
            wb_val_q   <= wb_val_d;
            list_q     <= list_d;
            rem_q      <= rem_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        u_d           = u_q;
        w_d           = w_q;
        l_d           = l_q;
        base_reg_d    = base_reg_q;
        base_d        = base_q;
        addr_d        = addr_q;
        wb_val_d      = wb_val_q;
        list_d        = list_q;
        rem_d         = rem_q;
        reg_addr_out  = '0;
        mem_addr_out  = '0;
        mem_rd_en_out = 1'b0;
        mem_wr_en_out = 1'b0;
        wb_en_out     = 1'b0;
        wb_data_out   = '0;
        busy_out      = 1'b0;
        done_out      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    p_d        = p_in;
                    u_d        = u_in;
                    w_d        = w_in;
                    l_d        = l_in;
                    base_reg_d = base_reg_in;
                    base_d     = base_in;
                    list_d     = reg_list_in;
                    rem_d      = reg_list_in;
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                busy_out = 1'b1;
                addr_d   = start_addr_c;
                wb_val_d = u_q ? (base_q + span_c) : (base_q - span_c);
                state_d  = (n_c == '0) ? ST_DONE : ST_XFER;
            end
            ST_XFER: begin
                busy_out      = 1'b1;
                reg_addr_out  = pick_idx;
                mem_addr_out  = addr_q;
                mem_rd_en_out = pick_valid & l_q;
                mem_wr_en_out = pick_valid & ~l_q;
                if (mem_ready_in) begin
                    rem_d  = rem_next;
                    addr_d = addr_q + WORD_INC;
                    if (rem_next == '0) begin
                        state_d = w_q ? ST_WB : ST_DONE;
                    end
                end
            end
            ST_WB: begin
                busy_out    = 1'b1;
                wb_en_out   = ~wb_suppress_c;
                wb_data_out = wb_val_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done_out = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rf_wr_en_out = mem_rd_en_out & mem_ready_in;

`ifdef LDM_STM_PC_FLUSH_EN
    assign pc_flush_out = (state_q == ST_DONE) & l_q & list_q[15];
`else
    assign pc_flush_out = 1'b0;
`endif

endmodule
